// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_pkg
// Brief    : Opcodes, FSM encoding and helpers shared by seq_arith_unit.
// Revision : 1.0
// ============================================================================
package arith_pkg;

  localparam logic [3:0] OP_ADD        = 4'd0;
  localparam logic [3:0] OP_SUB        = 4'd1;
  localparam logic [3:0] OP_AND        = 4'd2;
  localparam logic [3:0] OP_OR         = 4'd3;
  localparam logic [3:0] OP_XOR        = 4'd4;
  localparam logic [3:0] OP_NOT        = 4'd5;
  localparam logic [3:0] OP_SLA        = 4'd6;
  localparam logic [3:0] OP_SRA        = 4'd7;
  localparam logic [3:0] OP_SRL        = 4'd8;
  localparam logic [3:0] OP_MUL        = 4'd9;
  localparam logic [3:0] OP_DIV        = 4'd10;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : iter_muldiv
// Brief    : WIDTH-step unsigned shift-add multiplier / restoring divider.
// Revision : 1.0
// ============================================================================
module iter_muldiv #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  logic               r_busy;
  logic               r_div;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_b;

  logic [WIDTH:0]     w_add;
  logic [2*WIDTH:0]   w_mul_cat;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_trial;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;

  // Multiply: hi accumulates, lo holds the multiplier and shifts out LSB-first.
  // Divide: {hi,lo} = {remainder, dividend/quotient}, shifted left each step.
  always_comb begin
    w_add     = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_b}) : {1'b0, r_hi};
    w_mul_cat = {w_add, r_lo};
    w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
    w_trial   = w_rem_sh - {1'b0, r_b};
    w_borrow  = w_trial[WIDTH];
    if (r_div) begin
      w_hi_nxt = w_borrow ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], ~w_borrow};
    end else begin
      w_hi_nxt = w_mul_cat[2*WIDTH:WIDTH+1];
      w_lo_nxt = w_mul_cat[WIDTH:1];
    end
  end

  // The final step's value is exported combinationally so the top can load it
  // on the same edge that completes the operation.
  assign done   = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign result = {w_hi_nxt, w_lo_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_div  <= is_div;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= op_a;
      r_b    <= op_b;
    end else if (r_busy) begin
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_arith_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_arith_unit
// Brief    : Registered ALU with valid/ready handshakes and iterative MUL/DIV.
// Revision : 1.0
// ============================================================================
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] dport1,
  input  logic [WIDTH-1:0] dport2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             op_err
);

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic               r_is_div;
  logic               r_div_zero;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               r_z, r_n, r_c, r_v, r_err;

  logic               w_accept, w_start, w_load;
  logic               w_md_done;
  logic [2*WIDTH-1:0] w_md_result;
  logic [WIDTH:0]     w_sum, w_diff;
  logic [WIDTH-1:0]   w_sc_lo, w_res_lo, w_res_hi;
  logic               w_sc_c, w_sc_v, w_sc_err;
  logic               w_res_c, w_res_v, w_res_err;

  iter_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_start),
    .is_div (alu_ctrl == OP_DIV),
    .op_a   (dport1),
    .op_b   (dport2),
    .done   (w_md_done),
    .result (w_md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start)   w_state_nxt = BUSY;
      BUSY:    if (w_md_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
    w_accept = in_valid && in_ready;
    w_start  = w_accept && is_iter_op(alu_ctrl);
    w_load   = (w_accept && !is_iter_op(alu_ctrl)) || w_md_done;
  end

  assign w_sum  = {1'b0, dport1} + {1'b0, dport2};
  assign w_diff = {1'b0, dport1} - {1'b0, dport2};

  always_comb begin
    w_sc_lo  = '0;
    w_sc_c   = 1'b0;
    w_sc_v   = 1'b0;
    w_sc_err = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        w_sc_lo = w_sum[WIDTH-1:0];
        w_sc_c  = w_sum[WIDTH];
        w_sc_v  = (dport1[WIDTH-1] == dport2[WIDTH-1]) && (w_sum[WIDTH-1] != dport1[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_lo = w_diff[WIDTH-1:0];
        w_sc_c  = w_diff[WIDTH];
        w_sc_v  = (dport1[WIDTH-1] != dport2[WIDTH-1]) && (w_diff[WIDTH-1] != dport1[WIDTH-1]);
      end
      OP_AND: w_sc_lo = dport1 & dport2;
      OP_OR:  w_sc_lo = dport1 | dport2;
      OP_XOR: w_sc_lo = dport1 ^ dport2;
      OP_NOT: w_sc_lo = ~dport1;
      OP_SLA: begin
        w_sc_lo = {dport1[WIDTH-2:0], 1'b0};
        w_sc_c  = dport1[WIDTH-1];
        w_sc_v  = dport1[WIDTH-1] ^ dport1[WIDTH-2];
      end
      OP_SRA: begin
        w_sc_lo = {dport1[WIDTH-1], dport1[WIDTH-1:1]};
        w_sc_c  = dport1[0];
      end
      OP_SRL: begin
        w_sc_lo = {1'b0, dport1[WIDTH-1:1]};
        w_sc_c  = dport1[0];
      end
      OP_MUL, OP_DIV: w_sc_lo = '0;
      default: w_sc_err = (alu_ctrl > OP_LAST_LEGAL);
    endcase
  end

  // Completion of MUL/DIV can only happen in BUSY, so it never collides with
  // a single-cycle load.
  always_comb begin
    w_res_lo  = w_md_done ? w_md_result[WIDTH-1:0] : w_sc_lo;
    w_res_hi  = w_md_done ? w_md_result[2*WIDTH-1:WIDTH] : '0;
    w_res_c   = w_md_done ? (!r_is_div && (|w_md_result[2*WIDTH-1:WIDTH])) : w_sc_c;
    w_res_v   = w_md_done ? 1'b0 : w_sc_v;
    w_res_err = w_md_done ? (r_is_div && r_div_zero) : w_sc_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div    <= 1'b0;
      r_div_zero  <= 1'b0;
      r_out_valid <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_start) begin
        r_is_div   <= (alu_ctrl == OP_DIV);
        r_div_zero <= (dport2 == '0);
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_lo        <= w_res_lo;
        r_hi        <= w_res_hi;
        r_z         <= (w_res_lo == '0);
        r_n         <= w_res_lo[WIDTH-1];
        r_c         <= w_res_c;
        r_v         <= w_res_v;
        r_err       <= w_res_err;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign alu_out    = r_lo;
  assign alu_out_hi = r_hi;
  assign flag_z     = r_z;
  assign flag_n     = r_n;
  assign flag_c     = r_c;
  assign flag_v     = r_v;
  assign op_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_arith_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_arith_unit
// Brief    : Self-checking bench for seq_arith_unit against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_seq_arith_unit;

  localparam int    W = 16;
  localparam longint M = 64'd1 << W;

  logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    alu_ctrl;
  logic [W-1:0]  dport1, dport2, alu_out, alu_out_hi;
  logic          flag_z, flag_n, flag_c, flag_v, op_err;

  int checks   = 0;
  int failures = 0;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .dport1(dport1), .dport2(dport2),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .alu_out_hi(alu_out_hi),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .op_err(op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic z, n, c, v, e;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sgn(input longint x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  // Result of one operation from plain integer arithmetic.
  function automatic res_t model_op(input logic [3:0] op, input longint a, input longint b);
    res_t   r;
    longint s;
    r = '0;
    case (op)
      4'd0: begin s = a + b; r.lo = W'(s % M); r.c = (s >= M);
                  s = sgn(a) + sgn(b); r.v = (s > M/2 - 1) || (s < -(M/2)); end
      4'd1: begin r.lo = W'((a - b + M) % M); r.c = (a < b);
                  s = sgn(a) - sgn(b); r.v = (s > M/2 - 1) || (s < -(M/2)); end
      4'd2: r.lo = W'(a & b);
      4'd3: r.lo = W'(a | b);
      4'd4: r.lo = W'(a ^ b);
      4'd5: r.lo = W'(M - 1 - a);
      4'd6: begin r.lo = W'((a * 2) % M); r.c = (a >= M/2);
                  r.v = ((a / (M/2)) % 2) != ((a / (M/4)) % 2); end
      4'd7: begin r.lo = W'((a / 2) + ((a >= M/2) ? M/2 : 0)); r.c = (a % 2) == 1; end
      4'd8: begin r.lo = W'(a / 2); r.c = (a % 2) == 1; end
      4'd9: begin s = a * b; r.lo = W'(s % M); r.hi = W'(s / M); r.c = (s / M) != 0; end
      4'd10: begin
        if (b == 0) begin r.lo = W'(M - 1); r.hi = W'(a); r.e = 1'b1; end
        else begin r.lo = W'(a / b); r.hi = W'(a % b); end
      end
      default: r.e = 1'b1;
    endcase
    r.z = (r.lo == 0);
    r.n = (r.lo >= W'(M / 2));
    return r;
  endfunction

  // Transaction-level model: a pending iterative op completes WIDTH cycles after accept.
  bit   m_valid, m_pend, m_acc;
  int   m_cnt;
  res_t m_out, m_pres;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_pend = 0; m_acc = 0; m_cnt = 0; m_out = '0; m_pres = '0;
    end else begin
      bit   rdy, load;
      res_t r;
      rdy   = !m_pend && (!m_valid || out_ready);
      m_acc = in_valid && rdy;
      load  = 0;
      r     = '0;
      if (m_pend) begin
        m_cnt++;
        if (m_cnt == W) begin load = 1; r = m_pres; m_pend = 0; end
      end
      if (m_acc) begin
        if (alu_ctrl == 4'd9 || alu_ctrl == 4'd10) begin
          m_pend = 1; m_cnt = 0; m_pres = model_op(alu_ctrl, longint'(dport1), longint'(dport2));
        end else begin
          load = 1; r = model_op(alu_ctrl, longint'(dport1), longint'(dport2));
        end
      end
      if (load) begin m_out = r; m_valid = 1; end
      else if (out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid",  32'(out_valid),  32'(m_valid));
    chk("in_ready",   32'(in_ready),   32'(!m_pend && (!m_valid || out_ready)));
    chk("alu_out",    32'(alu_out),    32'(m_out.lo));
    chk("alu_out_hi", 32'(alu_out_hi), 32'(m_out.hi));
    chk("flags_zncv", {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, m_out.z, m_out.n, m_out.c, m_out.v});
    chk("op_err",     32'(op_err),     32'(m_out.e));
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got = 0;
    alu_ctrl = op; dport1 = a; dport2 = b; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (m_acc) begin got = 1; break; end
    end
    chk("accept_timeout", 32'(got), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
  endtask

  initial begin
    int lat;
    logic [3:0]   t_op [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd0, 4'd1};
    logic [W-1:0] t_a  [8] = '{16'hF0F0, 16'h1200, 16'hAAAA, 16'h00FF, 16'h4001, 16'h0003, 16'hFFFF, 16'h8000};
    logic [W-1:0] t_b  [8] = '{16'h3C3C, 16'h0034, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; dport1 = '0; dport2 = '0;
    idle(2);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_alu_out",   32'(alu_out),   32'd0);
    rst_n = 1'b1;
    idle(1);
    chk("reset_in_ready",  32'(in_ready),  32'd1);

    send(4'd0, 16'h7FFF, 16'h0001);
    chk("add_out", 32'(alu_out), 32'h8000);
    chk("add_nvcz", {28'd0, flag_n, flag_v, flag_c, flag_z}, 32'b1100);

    send(4'd1, 16'h0003, 16'h0005);
    chk("sub_out", 32'(alu_out), 32'hFFFE);
    chk("sub_cn", {30'd0, flag_c, flag_n}, 32'b11);

    send(4'd7, 16'h8002, 16'h0000);
    chk("sra_out", 32'(alu_out), 32'hC001);
    chk("sra_c", 32'(flag_c), 32'd0);

    for (int i = 0; i < 8; i++) send(t_op[i], t_a[i], t_b[i]);

    send(4'd9, 16'h1234, 16'h0100);
    wait_result(lat);
    chk("mul_latency", 32'(lat), 32'd16);
    chk("mul_lo", 32'(alu_out), 32'h3400);
    chk("mul_hi", 32'(alu_out_hi), 32'h0012);
    chk("mul_c", 32'(flag_c), 32'd1);

    send(4'd10, 16'd100, 16'd7);
    wait_result(lat);
    chk("div_q", 32'(alu_out), 32'd14);
    chk("div_r", 32'(alu_out_hi), 32'd2);

    send(4'd10, 16'h00AA, 16'h0000);
    wait_result(lat);
    chk("div0_latency", 32'(lat), 32'd16);
    chk("div0_q", 32'(alu_out), 32'hFFFF);
    chk("div0_r", 32'(alu_out_hi), 32'h00AA);
    chk("div0_err", 32'(op_err), 32'd1);

    send(4'd9, 16'hFFFF, 16'hFFFF);
    wait_result(lat);
    send(4'd10, 16'hFFFF, 16'h0001);
    wait_result(lat);

    // Backpressure, then retire-and-accept on one edge.
    idle(1);
    out_ready = 1'b0;
    send(4'd0, 16'h0001, 16'h0002);
    idle(5);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold", 32'(alu_out), 32'd3);
    alu_ctrl = 4'd1; dport1 = 16'd9; dport2 = 16'd4; in_valid = 1'b1;
    idle(2);
    chk("bp_ignored", 32'(alu_out), 32'd3);
    out_ready = 1'b1;
    idle(1);
    in_valid = 1'b0;
    chk("bp_new", 32'(alu_out), 32'd5);
    chk("bp_valid", 32'(out_valid), 32'd1);

    // Reset in the middle of a multiply.
    send(4'd9, 16'h00FF, 16'h0101);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_alu_out", 32'(alu_out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    idle(20);
    chk("rst_no_result", 32'(out_valid), 32'd0);

    send(4'd13, 16'h0005, 16'h0006);
    chk("ill_err", 32'(op_err), 32'd1);
    chk("ill_out", 32'(alu_out), 32'd0);
    chk("ill_z", 32'(flag_z), 32'd1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
